branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 209 ++++++++++++++++++++
 tb/tb_branch_predictor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and a non-speculative
// circular return-address stack; lookup is combinational, training happens at update.
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 12,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [63:0] f_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_is_br,
  input  logic        upd_is_jmp,
  input  logic        upd_is_call,
  input  logic        upd_is_ret,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [63:0] upd_pred_target,
  output logic        redirect,
  output logic [63:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC_W  = $clog2(RAS_DEPTH + 1);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [RP_W-1:0]  RP_LAST = RP_W'(RAS_DEPTH - 1);
  localparam logic [RC_W-1:0]  RC_FULL = RC_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    TYPE_BR  = 2'd0,
    TYPE_JMP = 2'd1,
    TYPE_RET = 2'd2
  } ent_type_e;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [63:0]        tgt_q  [ENTRIES];
  logic [CTR_W-1:0]   ctr_q  [ENTRIES];
  ent_type_e          type_q [ENTRIES];

  logic [63:0]        ras_q [RAS_DEPTH];
  logic [RP_W-1:0]    ras_top_q, ras_top_d;
  logic [RC_W-1:0]    ras_cnt_q, ras_cnt_d;

  function automatic logic [RP_W-1:0] ptr_inc(input logic [RP_W-1:0] p);
    return (p == RP_LAST) ? {RP_W{1'b0}} : p + RP_W'(1);
  endfunction

  function automatic logic [RP_W-1:0] ptr_dec(input logic [RP_W-1:0] p);
    return (p == {RP_W{1'b0}}) ? RP_LAST : p - RP_W'(1);
  endfunction

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Fetch-side prediction from pre-update state; falls through to pc+4.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = f_pc + 64'd4;
    if (reset && f_valid && f_hit) begin
      case (type_q[f_idx])
        TYPE_BR: begin
          if (ctr_q[f_idx][CTR_W-1]) begin
            pred_taken  = 1'b1;
            pred_target = tgt_q[f_idx];
          end else begin
            pred_taken  = 1'b0;
          end
        end
        TYPE_JMP: begin
          pred_taken  = 1'b1;
          pred_target = tgt_q[f_idx];
        end
        TYPE_RET: begin
          if (ras_cnt_q != {RC_W{1'b0}}) begin
            pred_taken  = 1'b1;
            pred_target = ras_q[ras_top_q];
          end else begin
            pred_taken  = 1'b0;
          end
        end
        default: pred_taken = 1'b0;
      endcase
    end else begin
      pred_taken = 1'b0;
    end
  end

  logic             ent_we;
  logic [63:0]      ent_tgt_d;
  logic [CTR_W-1:0] ent_ctr_d;
  ent_type_e        ent_type_d;

  // BTB entry write: counter training on branch hits, allocation otherwise.
  always_comb begin
    ent_we     = 1'b0;
    ent_tgt_d  = tgt_q[u_idx];
    ent_ctr_d  = ctr_q[u_idx];
    ent_type_d = type_q[u_idx];
    if (upd_valid && upd_is_br) begin
      if (u_hit) begin
        ent_we = 1'b1;
        if (upd_taken) begin
          ent_ctr_d = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CTR_W'(1);
        end else begin
          ent_ctr_d = (ctr_q[u_idx] == CTR_MIN) ? CTR_MIN : ctr_q[u_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        ent_we     = 1'b1;
        ent_tgt_d  = upd_target;
        ent_ctr_d  = CTR_WT;
        ent_type_d = TYPE_BR;
      end else begin
        ent_we = 1'b0;
      end
    end else if (upd_valid && upd_is_jmp) begin
      ent_we     = 1'b1;
      ent_tgt_d  = upd_target;
      ent_type_d = upd_is_ret ? TYPE_RET : TYPE_JMP;
    end else begin
      ent_we = 1'b0;
    end
  end

  logic            ras_push, ras_pop, ras_we;
  logic [RP_W-1:0] ras_waddr;

  assign ras_push = upd_valid && upd_is_call;
  assign ras_pop  = upd_valid && upd_is_ret && (ras_cnt_q != {RC_W{1'b0}});

  // Return stack: pop-then-push collapses to an in-place overwrite of the top.
  always_comb begin
    ras_we    = 1'b0;
    ras_waddr = ras_top_q;
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    if (ras_push && ras_pop) begin
      ras_we = 1'b1;
    end else if (ras_push) begin
      ras_we    = 1'b1;
      ras_waddr = ptr_inc(ras_top_q);
      ras_top_d = ptr_inc(ras_top_q);
      ras_cnt_d = (ras_cnt_q == RC_FULL) ? RC_FULL : ras_cnt_q + RC_W'(1);
    end else if (ras_pop) begin
      ras_top_d = ptr_dec(ras_top_q);
      ras_cnt_d = ras_cnt_q - RC_W'(1);
    end else begin
      ras_we = 1'b0;
    end
  end

  // Predictor state; reset discards any update presented while it is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= {ENTRIES{1'b0}};
      ras_top_q <= {RP_W{1'b0}};
      ras_cnt_q <= {RC_W{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= {TAG_W{1'b0}};
        tgt_q[i]  <= 64'd0;
        ctr_q[i]  <= CTR_WNT;
        type_q[i] <= TYPE_BR;
      end
      for (int j = 0; j < RAS_DEPTH; j++) begin
        ras_q[j] <= 64'd0;
      end
    end else begin
      if (ent_we) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= ent_tgt_d;
        ctr_q[u_idx]   <= ent_ctr_d;
        type_q[u_idx]  <= ent_type_d;
      end
      if (ras_we) begin
        ras_q[ras_waddr] <= upd_pc + 64'd4;
      end
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Mispredict detection compares the resolved outcome with what fetch assumed.
  always_comb begin
    redirect    = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + 64'd4;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle
// corners, and random traffic against an array/queue reference model.
module tb_branch_predictor;

  localparam int ENTRIES   = 16;
  localparam int TAG_W     = 12;
  localparam int CTR_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int IDX_W     = $clog2(ENTRIES);

  logic        clk, reset, f_valid, pred_taken, redirect;
  logic [63:0] f_pc, pred_target, redirect_pc;
  logic        upd_valid, upd_is_br, upd_is_jmp, upd_is_call, upd_is_ret;
  logic        upd_taken, upd_pred_taken;
  logic [63:0] upd_pc, upd_target, upd_pred_target;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br), .upd_is_jmp(upd_is_jmp),
    .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    longint unsigned tag;
    logic [63:0] tgt;
    int          ctr;
    int          typ;   // 0 branch, 1 jump, 2 return
  } ment_t;

  ment_t       m_btb [ENTRIES];
  logic [63:0] m_ras [$];
  localparam int CTR_TOP  = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(ENTRIES));
  endfunction

  function automatic longint unsigned m_tag(input logic [63:0] pc);
    return (pc >> (IDX_W + 2)) % (64'd1 << TAG_W);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_btb[i].v   = 1'b0;
      m_btb[i].ctr = CTR_HALF - 1;
    end
    m_ras.delete();
  endtask

  task automatic m_predict(input logic fv, input logic [63:0] pc,
                           output logic pt, output logic [63:0] tgt);
    int i;
    pt  = 1'b0;
    tgt = pc + 64'd4;
    i = m_idx(pc);
    if (fv && m_btb[i].v && m_btb[i].tag == m_tag(pc)) begin
      if (m_btb[i].typ == 0 && m_btb[i].ctr >= CTR_HALF) begin
        pt = 1'b1; tgt = m_btb[i].tgt;
      end else if (m_btb[i].typ == 1) begin
        pt = 1'b1; tgt = m_btb[i].tgt;
      end else if (m_btb[i].typ == 2 && m_ras.size() > 0) begin
        pt = 1'b1; tgt = m_ras[$];
      end
    end
  endtask

  task automatic m_update();
    int i;
    bit hit;
    if (!upd_valid) return;
    i   = m_idx(upd_pc);
    hit = m_btb[i].v && m_btb[i].tag == m_tag(upd_pc);
    if (upd_is_br) begin
      if (hit) begin
        if (upd_taken) m_btb[i].ctr = (m_btb[i].ctr < CTR_TOP) ? m_btb[i].ctr + 1 : CTR_TOP;
        else           m_btb[i].ctr = (m_btb[i].ctr > 0) ? m_btb[i].ctr - 1 : 0;
      end else if (upd_taken) begin
        m_btb[i].v = 1'b1; m_btb[i].tag = m_tag(upd_pc); m_btb[i].tgt = upd_target;
        m_btb[i].ctr = CTR_HALF; m_btb[i].typ = 0;
      end
    end else if (upd_is_jmp) begin
      m_btb[i].v = 1'b1; m_btb[i].tag = m_tag(upd_pc); m_btb[i].tgt = upd_target;
      m_btb[i].typ = upd_is_ret ? 2 : 1;
    end
    if (upd_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
    if (upd_is_call) begin
      m_ras.push_back(upd_pc + 64'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (reset) m_update();
    @(negedge clk);
  endtask

  task automatic set_upd(input logic uv, input logic [63:0] upc, input logic br, input logic jmp,
                         input logic call, input logic ret, input logic tk, input logic [63:0] utgt,
                         input logic ptk, input logic [63:0] ptgt);
    upd_valid = uv; upd_pc = upc; upd_is_br = br; upd_is_jmp = jmp;
    upd_is_call = call; upd_is_ret = ret; upd_taken = tk; upd_target = utgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic no_upd();
    set_upd(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic look(input string name, input logic [63:0] pc, input logic ept, input logic [63:0] etgt);
    f_valid = 1'b1; f_pc = pc;
    #1;
    chk({name, ".pred_taken"}, {63'd0, pred_taken}, {63'd0, ept});
    chk({name, ".pred_target"}, pred_target, etgt);
  endtask

  typedef struct {
    logic fv; logic [63:0] fpc;
    logic uv; logic [63:0] upc; logic br, jmp, tk; logic [63:0] utgt; logic ptk; logic [63:0] ptgt;
    logic e_pt; logic [63:0] e_tgt; logic e_rd; logic [63:0] e_rpc;
  } vec_t;

  function automatic vec_t mk(input logic fv, input logic [63:0] fpc, input logic uv, input logic [63:0] upc,
                              input logic br, input logic jmp, input logic tk, input logic [63:0] utgt,
                              input logic ptk, input logic [63:0] ptgt, input logic e_pt,
                              input logic [63:0] e_tgt, input logic e_rd, input logic [63:0] e_rpc);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.uv = uv; v.upc = upc; v.br = br; v.jmp = jmp; v.tk = tk;
    v.utgt = utgt; v.ptk = ptk; v.ptgt = ptgt; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_rd = e_rd; v.e_rpc = e_rpc;
    return v;
  endfunction

  function automatic logic [63:0] pool_pc();
    logic [63:0] base;
    if ($urandom_range(0, 19) == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
    base = ($urandom_range(0, 1) == 0) ? 64'h8000_0000 : 64'h8000_1000;
    return base + (64'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [13];
    logic [63:0] ras_exp [4];
    m_reset();
    reset = 1'b0; f_valid = 1'b0; f_pc = 64'd0; no_upd();
    @(negedge clk); @(negedge clk);

    // During reset: fall-through prediction, redirect still combinational
    set_upd(1'b1, 64'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2000, 1'b0, 64'd0);
    look("in_reset", 64'h8000_0000, 1'b0, 64'h8000_0004);
    chk("in_reset.redirect", {63'd0, redirect}, 64'd1);
    chk("in_reset.redirect_pc", redirect_pc, 64'h2000);
    no_upd();
    @(negedge clk);
    reset = 1'b1;

    vecs[0]  = mk(1, 64'h8000_0000, 0, 64'd0, 0, 0, 0, 64'd0, 0, 64'd0, 0, 64'h8000_0004, 0, 64'd0);
    vecs[1]  = mk(1, 64'h8000_0010, 1, 64'h8000_0010, 1, 0, 1, 64'h8000_0100, 0, 64'd0, 0, 64'h8000_0014, 1, 64'h8000_0100);
    vecs[2]  = mk(1, 64'h8000_0010, 0, 64'd0, 0, 0, 0, 64'd0, 0, 64'd0, 1, 64'h8000_0100, 0, 64'd0);
    vecs[3]  = mk(1, 64'h8000_0010, 1, 64'h8000_0010, 1, 0, 0, 64'h8000_0100, 1, 64'h8000_0100, 1, 64'h8000_0100, 1, 64'h8000_0014);
    vecs[4]  = mk(1, 64'h8000_0010, 1, 64'h8000_0010, 1, 0, 0, 64'h8000_0100, 0, 64'd0, 0, 64'h8000_0014, 0, 64'd0);
    vecs[5]  = mk(1, 64'h8000_0010, 1, 64'h8000_0010, 1, 0, 0, 64'h8000_0100, 0, 64'd0, 0, 64'h8000_0014, 0, 64'd0);
    vecs[6]  = mk(1, 64'h8000_0010, 1, 64'h8000_0010, 1, 0, 1, 64'h8000_0100, 0, 64'd0, 0, 64'h8000_0014, 1, 64'h8000_0100);
    vecs[7]  = mk(1, 64'h8000_0010, 0, 64'd0, 0, 0, 0, 64'd0, 0, 64'd0, 0, 64'h8000_0014, 0, 64'd0);
    vecs[8]  = mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 64'd0, 1, 64'd0, 0, 64'd0, 1, 64'd0);
    vecs[9]  = mk(0, 64'h8000_0200, 1, 64'h8000_0200, 0, 1, 1, 64'h9000, 1, 64'h8000, 0, 64'h8000_0204, 1, 64'h9000);
    vecs[10] = mk(1, 64'h8000_0200, 1, 64'h8000_0200, 0, 1, 1, 64'h9000, 1, 64'h9000, 1, 64'h9000, 0, 64'd0);
    vecs[11] = mk(1, 64'h8000_0030, 0, 64'h8000_0030, 1, 0, 1, 64'h8000_0700, 0, 64'd0, 0, 64'h8000_0034, 0, 64'd0);
    vecs[12] = mk(1, 64'h8000_0030, 0, 64'd0, 0, 0, 0, 64'd0, 0, 64'd0, 0, 64'h8000_0034, 0, 64'd0);

    foreach (vecs[i]) begin
      f_valid = vecs[i].fv; f_pc = vecs[i].fpc;
      set_upd(vecs[i].uv, vecs[i].upc, vecs[i].br, vecs[i].jmp, 1'b0, 1'b0, vecs[i].tk,
              vecs[i].utgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      chk($sformatf("vec%0d.pred_taken", i), {63'd0, pred_taken}, {63'd0, vecs[i].e_pt});
      chk($sformatf("vec%0d.pred_target", i), pred_target, vecs[i].e_tgt);
      chk($sformatf("vec%0d.redirect", i), {63'd0, redirect}, {63'd0, vecs[i].e_rd});
      if (vecs[i].e_rd) chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      tick();
    end

    // Aliasing: same index, different tag replaces the entry
    set_upd(1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
    look("alias_train", 64'h8000_0010, 1'b0, 64'h8000_0014); tick();
    set_upd(1'b1, 64'h8000_0050, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0500, 1'b0, 64'd0);
    look("alias_hit", 64'h8000_0010, 1'b1, 64'h8000_0100); tick();
    no_upd();
    look("alias_miss", 64'h8000_0010, 1'b0, 64'h8000_0014); tick();
    look("alias_new", 64'h8000_0050, 1'b1, 64'h8000_0500); tick();

    // Same-cycle lookup and first taken update
    set_upd(1'b1, 64'h8000_0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0800, 1'b0, 64'd0);
    look("same_cyc0", 64'h8000_0020, 1'b0, 64'h8000_0024); tick();
    no_upd();
    look("same_cyc1", 64'h8000_0020, 1'b1, 64'h8000_0800); tick();

    // RAS: return entry first (pop on empty stack is a no-op)
    set_upd(1'b1, 64'h8000_0044, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1234, 1'b0, 64'd0);
    look("ret_alloc", 64'h8000_0044, 1'b0, 64'h8000_0048); tick();
    no_upd();
    look("ret_empty", 64'h8000_0044, 1'b0, 64'h8000_0048); tick();
    for (int k = 1; k <= 5; k++) begin
      set_upd(1'b1, 64'(k) << 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h4000, 1'b1, 64'h4000);
      f_valid = 1'b0; #1;
      chk($sformatf("call%0d.redirect", k), {63'd0, redirect}, 64'd0);
      tick();
    end
    no_upd();
    ras_exp[0] = 64'h504; ras_exp[1] = 64'h404; ras_exp[2] = 64'h304; ras_exp[3] = 64'h204;
    for (int k = 0; k < 4; k++) begin
      set_upd(1'b1, 64'h8000_0044, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1234, 1'b0, 64'd0);
      look($sformatf("ras_pop%0d", k), 64'h8000_0044, 1'b1, ras_exp[k]); tick();
    end
    look("ras_pop4", 64'h8000_0044, 1'b0, 64'h8000_0048); tick();
    no_upd();
    look("ras_after_pop4", 64'h8000_0044, 1'b0, 64'h8000_0048); tick();

    // Call+return together replaces the top without changing depth
    set_upd(1'b1, 64'h600, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h4000, 1'b0, 64'd0);
    f_valid = 1'b0; tick();
    set_upd(1'b1, 64'h700, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h4000, 1'b0, 64'd0);
    look("callret_pre", 64'h8000_0044, 1'b1, 64'h604); tick();
    set_upd(1'b1, 64'h8000_0044, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1234, 1'b0, 64'd0);
    look("callret_top", 64'h8000_0044, 1'b1, 64'h704); tick();
    set_upd(1'b1, 64'h800, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h4000, 1'b0, 64'd0);
    look("callret_empty_pre", 64'h8000_0044, 1'b0, 64'h8000_0048); tick();
    set_upd(1'b1, 64'h8000_0044, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1234, 1'b0, 64'd0);
    look("callret_empty_top", 64'h8000_0044, 1'b1, 64'h804); tick();
    no_upd();
    look("callret_drained", 64'h8000_0044, 1'b0, 64'h8000_0048); tick();

    // Reset arriving mid-update discards it; next edge after release accepts it
    look("pre_reset", 64'h8000_0050, 1'b1, 64'h8000_0500);
    set_upd(1'b1, 64'h8000_0068, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0900, 1'b0, 64'd0);
    #1 reset = 1'b0;
    m_reset();
    look("during_reset", 64'h8000_0050, 1'b0, 64'h8000_0054);
    chk("during_reset.redirect", {63'd0, redirect}, 64'd1);
    chk("during_reset.redirect_pc", redirect_pc, 64'h8000_0900);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    look("discarded", 64'h8000_0068, 1'b0, 64'h8000_006C); tick();
    no_upd();
    look("first_accept", 64'h8000_0068, 1'b1, 64'h8000_0900);
    look("cleared_entry", 64'h8000_0050, 1'b0, 64'h8000_0054); tick();

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int kind;
      logic uv, br, jmp, call, ret, tk, ptk, ept, erd;
      logic [63:0] upc, utgt, ptgt, fpc, etgt, erpc;
      kind = $urandom_range(0, 5);
      uv   = ($urandom_range(0, 7) != 0);
      upc  = pool_pc();
      br   = (kind == 0);
      jmp  = (kind >= 1 && kind <= 4);
      call = (kind == 2 || kind == 4);
      ret  = (kind == 3 || kind == 4);
      tk   = br ? 1'($urandom_range(0, 1)) : (kind != 5);
      utgt = 64'h8000_0000 + (64'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 1) == 1) m_predict(1'b1, upc, ptk, ptgt);
      else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = 64'h8000_0000 + (64'($urandom_range(0, 63)) << 2);
      end
      fpc = pool_pc();
      f_valid = ($urandom_range(0, 4) != 0);
      f_pc = fpc;
      set_upd(uv, upc, br, jmp, call, ret, tk, utgt, ptk, ptgt);
      #1;
      m_predict(f_valid, fpc, ept, etgt);
      erd  = uv && ((tk != ptk) || (tk && utgt != ptgt));
      erpc = tk ? utgt : upc + 64'd4;
      chk($sformatf("rand%0d.pred_taken", n), {63'd0, pred_taken}, {63'd0, ept});
      chk($sformatf("rand%0d.pred_target", n), pred_target, etgt);
      chk($sformatf("rand%0d.redirect", n), {63'd0, redirect}, {63'd0, erd});
      if (erd) chk($sformatf("rand%0d.redirect_pc", n), redirect_pc, erpc);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
